pcs_block_sync: RTL and testbench

PCS_BLOCK_SYNC -- requirements
Module: pcs_block_sync

---
 rtl/pcs_block_sync.sv | 124 ++++++++++++
 tb/tb_pcs_block_sync.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_block_sync.sv
// 64b/66b PCS block synchroniser: hunts for sync-header alignment by slipping the gearbox,
// declares lock after a clean window. Optional stats outputs under `PCS_BLOCK_SYNC_STATS_EN`.
module pcs_block_sync #(
  parameter int HDR_WIDTH    = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [HDR_WIDTH-1:0] i_rx_hdr,
  input  logic                 i_rx_hdr_valid,
  output logic                 o_block_lock,
`ifdef PCS_BLOCK_SYNC_STATS_EN
  output logic [15:0]          o_slip_count,
  output logic [15:0]          o_lock_loss_count,
`endif
  output logic                 o_rx_slip
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    S_RESET_CNT,
    S_TEST_SH,
    S_SLIP,
    S_SLIP_WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   sh_cnt;
  logic [INV_W-1:0]   sh_invld_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               hdr_ok;
  logic [CNT_W-1:0]   cnt_inc;
  logic [INV_W-1:0]   invld_inc;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    hdr_ok    = (i_rx_hdr == HDR_WIDTH'(1)) || (i_rx_hdr == HDR_WIDTH'(2));
    cnt_inc   = sh_cnt + CNT_W'(1);
    invld_inc = sh_invld_cnt + (hdr_ok ? INV_W'(0) : INV_W'(1));
  end

  // NOTE: state and registered outputs use non-blocking assignments so every register
  // samples the same pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_RESET_CNT;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_rx_slip    <= 1'b0;
    end else begin
      o_rx_slip <= 1'b0;
      case (state)
        S_RESET_CNT: begin
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
          state        <= S_TEST_SH;
        end
        S_TEST_SH: begin
          if (i_rx_hdr_valid) begin
            sh_cnt       <= cnt_inc;
            sh_invld_cnt <= invld_inc;
            // Loss-of-lock outranks window completion when both land on the same header.
            if (!o_block_lock && !hdr_ok) begin
              state     <= S_SLIP;
              o_rx_slip <= 1'b1;
            end else if (o_block_lock && invld_inc == INV_W'(SH_INVLD_MAX)) begin
              o_block_lock <= 1'b0;
              state        <= S_SLIP;
              o_rx_slip    <= 1'b1;
            end else if (cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              o_block_lock <= 1'b1;
              state        <= S_RESET_CNT;
            end
          end
        end
        S_SLIP: begin
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
          wait_cnt     <= '0;
          state        <= (SLIP_WAIT == 0) ? S_RESET_CNT : S_SLIP_WAIT;
        end
        S_SLIP_WAIT: begin
          // Headers are discarded while the gearbox settles after the slip.
          if (i_rx_hdr_valid) begin
            if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
              wait_cnt <= '0;
              state    <= S_RESET_CNT;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        default: state <= S_RESET_CNT;
      endcase
    end
  end

`ifdef PCS_BLOCK_SYNC_STATS_EN
  logic lock_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_d            <= 1'b0;
      o_slip_count      <= '0;
      o_lock_loss_count <= '0;
    end else begin
      lock_d <= o_block_lock;
      if (o_rx_slip && o_slip_count != 16'hFFFF)
        o_slip_count <= o_slip_count + 16'd1;
      if (lock_d && !o_block_lock && o_lock_loss_count != 16'hFFFF)
        o_lock_loss_count <= o_lock_loss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcs_block_sync.sv
// Self-checking bench for pcs_block_sync: event-level reference model compared every cycle,
// plus directed literal checks on lock/slip timing.
module tb_pcs_block_sync;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hdr = 2'b00;
  logic       hdr_valid = 1'b0;
  logic       block_lock;
  logic       rx_slip;
`ifdef PCS_BLOCK_SYNC_STATS_EN
  logic [15:0] slip_count;
  logic [15:0] lock_loss_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int slip_seen = 0;

  pcs_block_sync #(
    .HDR_WIDTH   (2),
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX),
    .SLIP_WAIT   (SLIP_WAIT)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_rx_hdr         (hdr),
    .i_rx_hdr_valid   (hdr_valid),
    .o_block_lock     (block_lock),
`ifdef PCS_BLOCK_SYNC_STATS_EN
    .o_slip_count     (slip_count),
    .o_lock_loss_count(lock_loss_count),
`endif
    .o_rx_slip        (rx_slip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model in terms of header events: a window of 64 counted events, a one-cycle
  // dead time after each window/slip decision, and SLIP_WAIT ignored events after a slip.
  int m_lock = 0, m_slip = 0;
  int m_dead = 1, m_slipping = 0, m_ignore = 0;
  int m_total = 0, m_bad = 0;

  task automatic model_step();
    bit bad;
    if (rst) begin
      m_lock = 0; m_slip = 0; m_dead = 1; m_slipping = 0;
      m_ignore = 0; m_total = 0; m_bad = 0;
      return;
    end
    m_slip = 0;
    if (m_dead != 0) begin
      m_dead = 0; m_total = 0; m_bad = 0;
    end else if (m_slipping != 0) begin
      m_slipping = 0; m_total = 0; m_bad = 0;
      m_ignore = SLIP_WAIT;
      if (SLIP_WAIT == 0) m_dead = 1;
    end else if (m_ignore > 0) begin
      if (hdr_valid) begin
        m_ignore--;
        if (m_ignore == 0) m_dead = 1;
      end
    end else if (hdr_valid) begin
      bad = (hdr == 2'b00) || (hdr == 2'b11);
      m_total++;
      if (bad) m_bad++;
      if (m_lock == 0 && bad) begin
        m_slip = 1; m_slipping = 1;
      end else if (m_lock == 1 && m_bad == SH_INVLD_MAX) begin
        m_lock = 0; m_slip = 1; m_slipping = 1;
      end else if (m_total == SH_CNT_MAX) begin
        m_lock = 1; m_dead = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare process: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    int prev_slip = 0;
    forever begin
      @(negedge clk);
      check("block_lock_vs_model", int'(block_lock), m_lock);
      check("rx_slip_vs_model", int'(rx_slip), m_slip);
      if (rx_slip) begin
        check("rx_slip_not_consecutive", prev_slip, 0);
        slip_seen++;
      end
      prev_slip = int'(rx_slip);
    end
  end

  // One header event: valid high for one cycle, then low for one cycle.
  task automatic ev(input logic [1:0] h);
    hdr_valid = 1'b1;
    hdr       = h;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic evs(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) ev(h);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int nbad;
    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    check("reset_lock", int'(block_lock), 0);
    check("reset_slip", int'(rx_slip), 0);
    release_reset();

    // Acquisition: 64 valid events, lock one clock after the 64th
    evs(2'b01, 63);
    check("acq_lock_before_64th", int'(block_lock), 0);
    ev(2'b01);
    check("acq_lock_after_64th", int'(block_lock), 1);
    check("acq_no_slip", slip_seen, 0);

    // Locked window with 15 invalid headers spread through it
    nbad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 4 == 1 && nbad < 15) begin
        ev(2'b00);
        nbad++;
      end else begin
        ev(2'b01);
      end
    end
    check("window15_lock_kept", int'(block_lock), 1);
    check("window15_no_slip", slip_seen, 0);

    // Idle: valid low with an invalid header on the bus changes nothing
    hdr = 2'b00;
    repeat (100) begin @(posedge clk); #1; end
    check("idle_lock_kept", int'(block_lock), 1);
    check("idle_no_slip", slip_seen, 0);

    // Loss of lock after 16 invalid headers in one window
    evs(2'b00, 15);
    check("loss_lock_after_15", int'(block_lock), 1);
    ev(2'b00);
    check("loss_lock_after_16", int'(block_lock), 0);
    check("loss_one_slip", slip_seen, 1);
`ifdef PCS_BLOCK_SYNC_STATS_EN
    check("stats_lock_loss", int'(lock_loss_count), 1);
    check("stats_slip", int'(slip_count), 1);
`endif

    // Post-slip settle: four invalid headers are ignored
    evs(2'b00, 4);
    check("settle_ignored", slip_seen, 1);

    // Unlocked hunt: 10 valid then one invalid -> single slip, next 4 ignored
    evs(2'b10, 10);
    check("hunt_no_slip_yet", slip_seen, 1);
    ev(2'b11);
    check("hunt_one_slip", slip_seen, 2);
    ev(2'b00); ev(2'b11); ev(2'b00); ev(2'b01);
    check("hunt_wait_ignored", slip_seen, 2);
    evs(2'b01, 63);
    check("relock_before_64th", int'(block_lock), 0);
    ev(2'b01);
    check("relock_after_64th", int'(block_lock), 1);

    // Reset at event 40 of a fresh acquisition
    rst = 1'b1;
    release_reset();
    evs(2'b01, 40);
    #3 rst = 1'b1;
    #1;
    check("midreset_lock", int'(block_lock), 0);
    check("midreset_slip", int'(rx_slip), 0);
    release_reset();
    evs(2'b01, 63);
    check("reacq_lock_before_64th", int'(block_lock), 0);
    ev(2'b01);
    check("reacq_lock_after_64th", int'(block_lock), 1);

    // Back-to-back events: valid held high across window boundaries and slips
    hdr_valid = 1'b1;
    hdr       = 2'b01;
    repeat (200) begin @(posedge clk); #1; end
    check("stream_lock_kept", int'(block_lock), 1);
    hdr = 2'b00;
    repeat (40) begin @(posedge clk); #1; end
    check("stream_lock_lost", int'(block_lock), 0);
    hdr_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
